// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane geometry.
// Helpers map an address offset onto the effective lane offset and misalignment flag.
package mem_access_pkg;

   localparam int LANE_W    = 8;
   localparam int NUM_LANES = 4;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } size_e;

   typedef enum logic {
      ST_IDLE        = 1'b0,
      ST_MERGE_WRITE = 1'b1
   } state_e;

   // Low address bits below the access size are dropped (forced alignment).
   function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [1:0] off;
      case (size)
         SIZE_BYTE: off = addr_lo;
         SIZE_HALF: off = {addr_lo[1], 1'b0};
         default:   off = 2'b00;
      endcase
      return off;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SIZE_BYTE: mis = 1'b0;
         SIZE_HALF: mis = addr_lo[0];
         default:   mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: extracts/extends load lanes and merges store lanes into the old word.
// Zero latency, no flow control; little-endian lane k = bits [8k+7:8k].
module load_store_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        is_unsigned,
   input  logic [31:0] mem_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [31:0]          shifted;
   logic [31:0]          store_shifted;
   logic [NUM_LANES-1:0] lane_mask;
   logic [31:0]          bit_mask;

   assign shifted       = mem_word >> {offset, 3'b000};
   assign store_shifted = store_data << {offset, 3'b000};

   always_comb begin
      load_data = mem_word;
      case (size)
         SIZE_BYTE: load_data = is_unsigned ? {24'd0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
         SIZE_HALF: load_data = is_unsigned ? {16'd0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
         default:   load_data = mem_word;
      endcase
   end

   always_comb begin
      lane_mask = 4'b1111;
      case (size)
         SIZE_BYTE: lane_mask = 4'b0001 << offset;
         SIZE_HALF: lane_mask = 4'b0011 << offset;
         default:   lane_mask = 4'b1111;
      endcase
      bit_mask = '0;
      for (int k = 0; k < NUM_LANES; k++)
         bit_mask[k*LANE_W +: LANE_W] = {LANE_W{lane_mask[k]}};
   end

   assign merged_word = (mem_word & ~bit_mask) | (store_shifted & bit_mask);

endmodule

// File: rtl/memory_access_unit.sv
// Load/store unit: 1-cycle loads, 1-cycle word stores, 2-cycle read-merge-write sub-word stores (o_stall
// high in the read cycle). Optional MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module memory_access_unit
   import mem_access_pkg::*;
#(
   parameter int NB_ADDR = 32,
   parameter int NB_DATA = 32
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic               i_mem_read,
   input  logic               i_mem_write,
   input  logic [1:0]         i_size,
   input  logic               i_unsigned,
   input  logic [NB_ADDR-1:0] i_address,
   input  logic [NB_DATA-1:0] i_store_data,
   output logic               o_stall,
   output logic [NB_DATA-1:0] o_load_data,
   output logic               o_load_valid,
   output logic               o_misaligned,
   output logic               o_mem_write_enable,
   output logic               o_mem_read_enable,
   output logic [NB_ADDR-1:0] o_mem_write_address,
   output logic [NB_ADDR-1:0] o_mem_read_address,
   output logic [NB_DATA-1:0] o_mem_data,
   input  logic [NB_DATA-1:0] i_mem_data
);

   state_e             state, next_state;
   logic [NB_ADDR-1:0] word_addr;
   logic [1:0]         offset;
   logic               mis, accept, do_store, do_load, sub_store;
   logic [NB_DATA-1:0] aligned_load, merged_word;
   logic [NB_ADDR-1:0] merge_addr_q;
   logic [NB_DATA-1:0] merge_data_q;

   assign word_addr = i_address >> 2;
   assign offset    = eff_offset(i_size, i_address[1:0]);

`ifdef MISALIGN_CHECK_EN
   assign mis = (state == ST_IDLE) & i_valid & (i_mem_read | i_mem_write)
              & is_misaligned(i_size, i_address[1:0]);
`else
   assign mis = 1'b0;
`endif

   // Store wins when read and write are both requested.
   assign accept    = (state == ST_IDLE) & i_valid & ~mis;
   assign do_store  = accept & i_mem_write;
   assign do_load   = accept & i_mem_read & ~i_mem_write;
   assign sub_store = do_store & ((i_size == SIZE_BYTE) | (i_size == SIZE_HALF));

   load_store_align u_align (
      .size        (i_size),
      .offset      (offset),
      .is_unsigned (i_unsigned),
      .mem_word    (i_mem_data),
      .store_data  (i_store_data),
      .load_data   (aligned_load),
      .merged_word (merged_word)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:        if (sub_store) next_state = ST_MERGE_WRITE;
         ST_MERGE_WRITE: next_state = ST_IDLE;
         default:        next_state = ST_IDLE;
      endcase
   end

   assign o_mem_read_address = word_addr;

   // Reset gates the enables so a merge write caught mid-flight never reaches memory.
   always_comb begin
      o_stall             = 1'b0;
      o_mem_read_enable   = 1'b0;
      o_mem_write_enable  = 1'b0;
      o_mem_write_address = word_addr;
      o_mem_data          = i_store_data;
      if (!i_reset) begin
         case (state)
            ST_IDLE: begin
               o_stall            = sub_store;
               o_mem_read_enable  = do_load | sub_store;
               o_mem_write_enable = do_store & ~sub_store;
            end
            ST_MERGE_WRITE: begin
               o_mem_write_enable  = 1'b1;
               o_mem_write_address = merge_addr_q;
               o_mem_data          = merge_data_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_load_data  <= '0;
         o_load_valid <= 1'b0;
         o_misaligned <= 1'b0;
         merge_addr_q <= '0;
         merge_data_q <= '0;
      end else begin
         o_load_valid <= do_load;
         o_misaligned <= mis;
         if (do_load) o_load_data <= aligned_load;
         if (sub_store) begin
            merge_addr_q <= word_addr;
            merge_data_q <= merged_word;
         end
      end
   end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameters SHALL be: NB_ADDR, default 32, byte-address width; NB_DATA, default 32, data width (only 32 supported).
REQ-002 Ports SHALL be: i_clock  in  1  single clock, all state on rising edge.
REQ-003 i_reset  in  1  asynchronous, active-high reset.
REQ-004 i_valid  in  1  memory request present; i_mem_read  in  1  load; i_mem_write  in  1  store.
REQ-005 i_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word); i_unsigned  in  1  zero-extend loads.
REQ-006 i_address  in  NB_ADDR  byte address; i_store_data  in  NB_DATA  store operand, right-justified.
REQ-007 o_stall  out  1  upstream SHALL hold its request stable while high.
REQ-008 o_load_data  out  NB_DATA  aligned, extended load result; o_load_valid  out  1  one-cycle pulse; o_misaligned  out  1  one-cycle pulse.
REQ-009 o_mem_write_enable, o_mem_read_enable  out  1; o_mem_write_address, o_mem_read_address  out  NB_ADDR  word address = i_address >> 2; o_mem_data  out  NB_DATA  word to write; i_mem_data  in  NB_DATA  combinational read data from the data memory.

Function
REQ-010 States SHALL be IDLE and MERGE_WRITE; reset state IDLE.
REQ-011 Byte lanes SHALL be little-endian: lane k = bits [8k+7:8k], selected by i_address[1:0].
REQ-012 Load (IDLE, i_valid, i_mem_read, !i_mem_write): o_mem_read_enable high combinationally; lane select and sign/zero extension of i_mem_data registered; o_load_valid pulses next cycle (latency 1).
REQ-013 Word store (IDLE): o_mem_write_enable high combinationally with o_mem_data = i_store_data; written on that edge; o_stall low.
REQ-014 Byte/half store (IDLE): read old word, merge i_store_data into addressed lane(s), register merged word; o_stall high combinationally; next state MERGE_WRITE.
REQ-015 MERGE_WRITE: drive registered address/merged word with o_mem_write_enable high; o_stall low; held inputs SHALL be ignored (request counts as consumed); next state IDLE.
REQ-016 i_mem_read and i_mem_write both high SHALL be executed as a store only.
REQ-017 i_valid low in IDLE: all memory enables low, no state change, no pulses.
REQ-018 Back-to-back requests SHALL be accepted every cycle in IDLE; a sub-word store costs exactly 2 cycles.
REQ-019 o_load_data SHALL hold its last value between loads.

Reset
REQ-020 Reset SHALL force IDLE, clear o_load_data, o_load_valid, o_misaligned, the merge registers, and deassert all memory enables and o_stall.
REQ-021 Reset asserted during MERGE_WRITE SHALL abort the pending write; no write occurs.

Configuration
REQ-022 With MISALIGN_CHECK_EN defined: half at odd address or word with address[1:0] != 0 SHALL perform no memory access, pulse o_misaligned next cycle, and not pulse o_load_valid.
REQ-023 Without MISALIGN_CHECK_EN: low address bits below the access size SHALL be ignored (forced alignment); o_misaligned tied 0.

Structure
REQ-024 Package mem_access_pkg SHALL hold size encodings, state encodings and lane-width constants.
REQ-025 Sub-module load_store_align SHALL implement combinational lane select/extension and store merge; FSM and registers stay in memory_access_unit.

Verification
REQ-026 Word load addr 0x10, memory word 0xDEADBEEF -> read address 0x4, next cycle o_load_valid=1, o_load_data=0xDEADBEEF.
REQ-027 Signed byte load addr 0x13, word 0x80FF0011 -> o_load_data=0xFFFFFF80; unsigned -> 0x00000080.
REQ-028 Byte store 0xAB to addr 0x21, old word 0x11223344 -> cycle 0 o_stall=1, no write; cycle 1 write address 0x8, data 0x1122AB44, o_stall=0.
REQ-029 Half store to 0x5 with MISALIGN_CHECK_EN -> no write enable, o_misaligned pulse next cycle; without macro -> lanes 0-1 of word 1 written.
REQ-030 Reset asserted in MERGE_WRITE -> o_mem_write_enable=0, memory unchanged, state IDLE.
REQ-031 Word store followed immediately by word load of same address -> load returns the stored value, no stall.
